// File: rtl/kmc_clkgen.sv
// KMC11 microcycle timing generator: run/step/maintenance-write control and per-phase enables.
// Optional breakpoint halt is compiled in with `define KMC_BREAKPOINT_EN.
module kmc_clkgen #(
  parameter int PHASES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kmcINIT,
  input  logic       kmcRUN,
  input  logic       kmcSTEP,
  input  logic       kmcCRAMOUT,
  input  logic       kmcCRAMWRREQ,
  input  logic       kmcWAIT,
  input  logic [9:0] kmcPC,
  input  logic [9:0] kmcBRKADDR,
  input  logic       kmcBRKEN,
  output logic       kmcALUCLKEN,
  output logic       kmcPCCLKEN,
  output logic       kmcCRAMCLKEN,
  output logic       kmcCRAMWR,
  output logic       kmcSTEPDONE,
  output logic       kmcRUNNING,
  output logic       kmcBRKHIT
);

  localparam logic [3:0] PH_ALU  = 4'(PHASES - 2);
  localparam logic [3:0] PH_LAST = 4'(PHASES - 1);

  typedef enum logic [1:0] {IDLE, RUN, STEP, WRITE} state_t;

  state_t     state, stateNxt;
  logic [3:0] ph, phNxt;
  logic       runReq;
  logic       brkMatch;
  logic       brkSet;
  logic       stepAccept;
  logic       initAny;

  assign initAny = rst | kmcINIT;

`ifdef KMC_BREAKPOINT_EN
  logic runPrev;
  logic brkHit;

  // Edge-triggered entry so a breakpoint halt is not immediately re-run while kmcRUN stays high.
  always_ff @(posedge clk) begin
    if (initAny) begin
      runPrev <= 1'b0;
      brkHit  <= 1'b0;
    end else begin
      runPrev <= kmcRUN;
      if (brkSet)
        brkHit <= 1'b1;
      else if (stepAccept)
        brkHit <= 1'b0;
    end
  end

  assign runReq    = kmcRUN & ~runPrev;
  assign brkMatch  = kmcBRKEN & (kmcPC == kmcBRKADDR);
  assign kmcBRKHIT = brkHit;
`else
  logic unusedBrk;

  assign runReq    = kmcRUN;
  assign brkMatch  = 1'b0;
  assign kmcBRKHIT = 1'b0;
  assign unusedBrk = ^{kmcPC, kmcBRKADDR, kmcBRKEN, brkSet, stepAccept};
`endif

  always_ff @(posedge clk) begin
    if (initAny) begin
      state       <= IDLE;
      ph          <= 4'd0;
      kmcSTEPDONE <= 1'b0;
    end else begin
      state       <= stateNxt;
      ph          <= phNxt;
      kmcSTEPDONE <= (state == STEP) && (ph == PH_LAST);
    end
  end

  always_comb begin
    stateNxt     = state;
    phNxt        = ph;
    brkSet       = 1'b0;
    stepAccept   = 1'b0;
    kmcALUCLKEN  = 1'b0;
    kmcPCCLKEN   = 1'b0;
    kmcCRAMCLKEN = 1'b0;
    kmcCRAMWR    = 1'b0;
    kmcRUNNING   = (state == RUN) || (state == STEP);

    unique case (state)
      IDLE: begin
        phNxt = 4'd0;
        // Losing requests are dropped, not queued.
        if (runReq) begin
          stateNxt = RUN;
        end else if (kmcSTEP && !kmcRUN) begin
          stateNxt   = STEP;
          stepAccept = 1'b1;
        end else if (kmcCRAMWRREQ && kmcCRAMOUT) begin
          stateNxt = WRITE;
        end
      end

      RUN, STEP: begin
        if (ph == PH_ALU) begin
          if (!kmcWAIT) begin
            kmcALUCLKEN = 1'b1;
            kmcPCCLKEN  = 1'b1;
            phNxt       = ph + 4'd1;
          end
        end else if (ph == PH_LAST) begin
          kmcCRAMCLKEN = 1'b1;
          phNxt        = 4'd0;
          // Run stop is only honoured at the microcycle boundary.
          if (state == STEP) begin
            stateNxt = IDLE;
          end else if (!kmcRUN) begin
            stateNxt = IDLE;
          end else if (brkMatch) begin
            stateNxt = IDLE;
            brkSet   = 1'b1;
          end
        end else begin
          phNxt = ph + 4'd1;
        end
      end

      WRITE: begin
        kmcCRAMWR = 1'b1;
        stateNxt  = IDLE;
        phNxt     = 4'd0;
      end

      default: begin
        stateNxt = IDLE;
        phNxt    = 4'd0;
      end
    endcase
  end

endmodule
